// File: rtl/deadlock_mon_pkg.sv
// Shared types and helpers for the persistence-filtered deadlock monitor.
package deadlock_mon_pkg;

   typedef enum logic [1:0] {S_IDLE, S_WATCH, S_BLOCK} state_e;

   // Width needed to encode channel indices 0..n, where n marks the child-instance origin.
   function automatic int unsigned clog2_ch(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-index-first priority encoder with a valid flag.
module prio_enc_lsb #(
   parameter int unsigned N = 13,
   parameter int unsigned W = 4
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      // Walk downwards so the lowest set bit wins.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/deadlock_persist_monitor.sv
// Flags deadlock once a masked stream block or child-instance block persists for THRESHOLD
// cycles, reporting the originating channel and how long the flag has been up.
module deadlock_persist_monitor
   import deadlock_mon_pkg::*;
#(
   parameter int unsigned N_AXIS    = 13,
   parameter int unsigned N_IDLE    = 15,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned THRESHOLD = 16,
   parameter bit          STICKY    = 1'b1,
   localparam int unsigned CH_W     = clog2_ch(N_AXIS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_AXIS-1:0] axis_block_sigs,
   input  logic [N_AXIS-1:0] ch_mask,
   input  logic [N_IDLE-1:0] inst_idle_sigs,
   input  logic              inst_block_sigs,
   input  logic              clear,
   output logic              block,
   output logic [CH_W-1:0]   first_ch,
   output logic [CNT_W-1:0]  block_cycles
);

   localparam int unsigned      CNT_MAX      = (32'd1 << CNT_W) - 32'd1;
   localparam logic [CNT_W-1:0] CNT_SAT      = '1;
   localparam logic [CNT_W-1:0] PERSIST_LAST = CNT_W'(THRESHOLD - 1);
   localparam logic [CH_W-1:0]  ORIGIN_INST  = CH_W'(N_AXIS);

   if (THRESHOLD == 0 || THRESHOLD > CNT_MAX) begin : g_bad_threshold
      $error("deadlock_persist_monitor: THRESHOLD must lie in 1..2**CNT_W-1");
   end

   logic [N_AXIS-1:0] cand;
   logic              all_idle;
   logic              hit;
   logic [CH_W-1:0]   enc_idx;
   logic              enc_valid;

   assign cand     = axis_block_sigs & ch_mask;
   assign all_idle = &inst_idle_sigs;
   assign hit      = ((|cand) | inst_block_sigs) & ~all_idle;

   prio_enc_lsb #(
      .N (N_AXIS),
      .W (CH_W)
   ) u_prio_enc (
      .req   (cand),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   state_e           state_q;
   logic [CNT_W-1:0] persist_q;
   logic             block_q;
   logic [CH_W-1:0]  first_ch_q;
   logic [CNT_W-1:0] block_cycles_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         persist_q      <= '0;
         block_q        <= 1'b0;
         first_ch_q     <= '0;
         block_cycles_q <= '0;
      end else if (clear) begin
         state_q        <= S_IDLE;
         persist_q      <= '0;
         block_q        <= 1'b0;
         first_ch_q     <= '0;
         block_cycles_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (hit) begin
                  first_ch_q <= enc_valid ? enc_idx : ORIGIN_INST;
                  if (THRESHOLD == 1) begin
                     state_q        <= S_BLOCK;
                     block_q        <= 1'b1;
                     block_cycles_q <= CNT_W'(1);
                  end else begin
                     state_q   <= S_WATCH;
                     persist_q <= CNT_W'(1);
                  end
               end
            end
            S_WATCH: begin
               if (!hit) begin
                  state_q   <= S_IDLE;
                  persist_q <= '0;
               end else if (persist_q == PERSIST_LAST) begin
                  state_q        <= S_BLOCK;
                  persist_q      <= '0;
                  block_q        <= 1'b1;
                  block_cycles_q <= CNT_W'(1);
               end else begin
                  persist_q <= persist_q + CNT_W'(1);
               end
            end
            S_BLOCK: begin
               // Sticky instances only leave through clear or reset.
               if (!STICKY && !hit) begin
                  state_q        <= S_IDLE;
                  block_q        <= 1'b0;
                  block_cycles_q <= '0;
               end else if (block_cycles_q != CNT_SAT) begin
                  block_cycles_q <= block_cycles_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign block        = block_q;
   assign first_ch     = first_ch_q;
   assign block_cycles = block_cycles_q;

endmodule

// File: doc/deadlock_persist_monitor.md
Name: deadlock_persist_monitor

Overview:
Parametrised successor to the per-instance deadlock monitors in the C/RTL co-sim harness. It watches N_AXIS stream-block flags plus child-instance block flags, requires a block condition to persist for THRESHOLD consecutive cycles before flagging deadlock, and suppresses detection while the whole instance is idle. It reports the originating channel and the flag duration, and it optionally latches the flag until an explicit clear. One instance per monitored dataflow module; the `block` outputs are OR-reduced by the parent monitor.

Parameters:
N_AXIS, 13, number of axis block inputs
N_IDLE, 15, number of instance idle inputs
CNT_W, 8, width of persistence and duration counters
THRESHOLD, 16, consecutive block cycles required before flagging (1..2^CNT_W-1)
STICKY, 1, 1 = flag held until clear; 0 = flag follows the condition

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
axis_block_sigs  in  N_AXIS  per-channel stream-block flags
ch_mask  in  N_AXIS  1 = channel monitored
inst_idle_sigs  in  N_IDLE  per-instance idle flags
inst_block_sigs  in  1  aggregated child-instance block
clear  in  1  synchronous clear of the flag and captured info
block  out  1  deadlock flag
first_ch  out  CH_W=$clog2(N_AXIS+1)  origin channel; value N_AXIS = inst_block_sigs origin
block_cycles  out  CNT_W  cycles `block` has been high, saturating

Behaviour:
- Combinational terms:
  - cand = axis_block_sigs & ch_mask
  - all_idle = &inst_idle_sigs
  - hit = (|cand | inst_block_sigs) & ~all_idle
- Reset (reset==0, asynchronous): state=S_IDLE, persist_cnt=0, block=0, first_ch=0, block_cycles=0.
- FSM states:
  - S_IDLE:
    - hit && THRESHOLD==1 -> S_BLOCK.
    - hit -> S_WATCH with persist_cnt=1.
    - Either transition captures first_ch = lowest set index of cand, or N_AXIS if cand==0.
  - S_WATCH:
    - !hit -> S_IDLE, persist_cnt=0.
    - hit && persist_cnt==THRESHOLD-1 -> S_BLOCK.
    - Otherwise persist_cnt+1.
    - first_ch holds.
  - S_BLOCK:
    - block=1; block_cycles increments each cycle, saturating at 2^CNT_W-1.
    - STICKY=0 and !hit -> S_IDLE with block_cycles cleared on the same edge.
    - STICKY=1 -> stay in S_BLOCK until clear.
- Latency: `block` rises exactly THRESHOLD edges after the first edge sampling hit=1. THRESHOLD=1, STICKY=0 reproduces the legacy single-register monitor: one-cycle latency, follows the condition.
- A single-cycle drop of hit in S_WATCH restarts the count; there is no hysteresis.
- all_idle=1 forces hit=0, so S_WATCH aborts. In S_BLOCK, STICKY=0 drops the flag; STICKY=1 holds it.
- clear has priority over everything. On the next edge: state=S_IDLE, persist_cnt=0, block=0, first_ch=0, block_cycles=0. hit in the same cycle is ignored; detection restarts the following cycle.
- ch_mask changes take effect on the next sample. A channel masked mid-WATCH drops out of hit immediately.
- first_ch is captured once per episode and never updated while in S_WATCH or S_BLOCK.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Elaboration error if THRESHOLD==0 or THRESHOLD>2^CNT_W-1.

Decomposition:
- Package deadlock_mon_pkg holds:
  - state enum {S_IDLE, S_WATCH, S_BLOCK}
  - function clog2_ch(n)
  - constant ORIGIN_INST encoding (=N_AXIS, computed locally)
- One sub-module, prio_enc_lsb (parametrised N_AXIS -> CH_W, valid output), used for the first_ch capture.

Test Plan:
- THRESHOLD=4, ch_mask=all 1, bit 5 high continuously -> block=1 exactly 4 edges after first sample; first_ch=5; block_cycles counts 1,2,3...
- THRESHOLD=4, bit 5 high 3 cycles, low 1, high 4 -> no block in the first burst; block at the 4th edge of the second burst.
- Bits 2 and 9 rise together, ch_mask[2]=0 -> first_ch=9; then inst_block_sigs alone (cand=0) in a fresh episode -> first_ch=13.
- STICKY=1, block held, axis_block_sigs drops to 0 -> block stays 1; clear pulse -> block=0 and first_ch=0 next edge, even with hit=1 that cycle.
- THRESHOLD=1, STICKY=0 -> block tracks hit with one-cycle delay; all inst_idle_sigs=1 with bit 3 high -> block stays 0.
- Async reset asserted mid-S_WATCH and mid-S_BLOCK, off-edge -> all outputs 0 immediately; CNT_W=2 with a long block -> block_cycles saturates at 3.
